// File: rtl/bist_seq_controller.sv
// BIST sequencer: steps N test vectors through reset / apply / clock / capture / check
// and reports completion, pass/fail and a saturating mismatch count.
module bist_seq_controller #(
   parameter int unsigned DEPTH_W       = 2,
   parameter int unsigned LOG_CYC       = 2,
   parameter int unsigned RESET_PER_VEC = 0
) (
   input  logic               BIST_clk,
   input  logic               BIST_res,
   input  logic               BIST_start,
   input  logic               BIST_abort,
   input  logic               Cmp_mismatch,
   output logic               Counter_incr_en,
   output logic               Counter_res,
   output logic               Mem_we,
   output logic               Mem_res,
   output logic               Bufer_we,
   output logic               Bufer_res,
   output logic               Set_error,
   output logic               Out_buf_res,
   output logic               En_Log_clk,
   output logic               Log_RES,
   output logic [DEPTH_W-1:0] Vec_addr,
   output logic [DEPTH_W:0]   Err_count,
   output logic               BIST_busy,
   output logic               BIST_done,
   output logic               BIST_pass,
   output logic [3:0]         State_code
);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      CLEAR   = 4'd1,
      LOG_RST = 4'd2,
      APPLY   = 4'd3,
      CLK     = 4'd4,
      CAPTURE = 4'd5,
      CHECK   = 4'd6,
      NEXT    = 4'd7,
      DONE    = 4'd8
   } state_t;

   localparam logic [DEPTH_W-1:0] LAST_VEC  = '1;
   localparam logic [DEPTH_W:0]   ERR_MAX   = '1;
   localparam logic [3:0]         CYC_LAST  = 4'(LOG_CYC - 1);
   localparam state_t             VEC_ENTRY = (RESET_PER_VEC != 0) ? LOG_RST : APPLY;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] cyc_cnt;
   logic       mis_lat;
   logic       mis_nxt;
   logic       abort_run;

   logic counter_incr_d;
   logic counter_res_d;
   logic mem_we_d;
   logic mem_res_d;
   logic bufer_we_d;
   logic bufer_res_d;
   logic set_error_d;
   logic out_buf_res_d;
   logic en_log_clk_d;
   logic log_res_d;
   logic busy_d;

   assign abort_run  = (state != IDLE) && BIST_abort;
   assign mis_nxt    = (state == CHECK) ? Cmp_mismatch : mis_lat;
   assign State_code = state;

   always_ff @(posedge BIST_clk or negedge BIST_res) begin
      if (!BIST_res) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (BIST_start && !BIST_abort) state_nxt = CLEAR;
         CLEAR:   state_nxt = LOG_RST;
         LOG_RST: state_nxt = APPLY;
         APPLY:   state_nxt = CLK;
         CLK:     if (cyc_cnt == CYC_LAST) state_nxt = CAPTURE;
         CAPTURE: state_nxt = CHECK;
         CHECK:   state_nxt = NEXT;
         NEXT:    state_nxt = (Vec_addr == LAST_VEC) ? DONE : VEC_ENTRY;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort_run) begin
         state_nxt = IDLE;
      end
   end

   // Controls are decoded from the next state and registered, so each one
   // is high exactly while the FSM sits in its owning state.
   always_comb begin
      counter_incr_d = 1'b0;
      counter_res_d  = 1'b0;
      mem_we_d       = 1'b0;
      mem_res_d      = 1'b0;
      bufer_we_d     = 1'b0;
      bufer_res_d    = 1'b0;
      set_error_d    = 1'b0;
      out_buf_res_d  = 1'b0;
      en_log_clk_d   = 1'b0;
      log_res_d      = 1'b0;
      busy_d         = (state_nxt != IDLE);
      case (state_nxt)
         CLEAR: begin
            counter_res_d = 1'b1;
            mem_res_d     = 1'b1;
            bufer_res_d   = 1'b1;
            out_buf_res_d = 1'b1;
         end
         LOG_RST: log_res_d    = 1'b1;
         APPLY:   bufer_we_d   = 1'b1;
         CLK:     en_log_clk_d = 1'b1;
         CAPTURE: mem_we_d     = 1'b1;
         NEXT: begin
            counter_incr_en_set: begin
               counter_incr_d = 1'b1;
               set_error_d    = mis_nxt;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge BIST_clk or negedge BIST_res) begin
      if (!BIST_res) begin
         Counter_incr_en <= 1'b0;
         Counter_res     <= 1'b0;
         Mem_we          <= 1'b0;
         Mem_res         <= 1'b0;
         Bufer_we        <= 1'b0;
         Bufer_res       <= 1'b0;
         Set_error       <= 1'b0;
         Out_buf_res     <= 1'b0;
         En_Log_clk      <= 1'b0;
         Log_RES         <= 1'b0;
         BIST_busy       <= 1'b0;
      end else begin
         Counter_incr_en <= counter_incr_d;
         Counter_res     <= counter_res_d;
         Mem_we          <= mem_we_d;
         Mem_res         <= mem_res_d;
         Bufer_we        <= bufer_we_d;
         Bufer_res       <= bufer_res_d;
         Set_error       <= set_error_d;
         Out_buf_res     <= out_buf_res_d;
         En_Log_clk      <= en_log_clk_d;
         Log_RES         <= log_res_d;
         BIST_busy       <= busy_d;
      end
   end

   // Err_count uses the mismatch value being latched on the CHECK->NEXT edge,
   // so the count is already updated while NEXT is active.
   always_ff @(posedge BIST_clk or negedge BIST_res) begin
      if (!BIST_res) begin
         cyc_cnt   <= '0;
         mis_lat   <= 1'b0;
         Vec_addr  <= '0;
         Err_count <= '0;
         BIST_done <= 1'b0;
         BIST_pass <= 1'b0;
      end else begin
         mis_lat <= mis_nxt;

         if (state == APPLY) begin
            cyc_cnt <= '0;
         end else if (state == CLK) begin
            cyc_cnt <= cyc_cnt + 1'b1;
         end

         if (state_nxt == CLEAR) begin
            Vec_addr  <= '0;
            Err_count <= '0;
         end else begin
            if ((state == NEXT) && (state_nxt != IDLE) && (state_nxt != DONE)) begin
               Vec_addr <= Vec_addr + 1'b1;
            end
            if ((state == CHECK) && (state_nxt == NEXT) && Cmp_mismatch && (Err_count != ERR_MAX)) begin
               Err_count <= Err_count + 1'b1;
            end
         end

         if ((state_nxt == CLEAR) || abort_run) begin
            BIST_done <= 1'b0;
            BIST_pass <= 1'b0;
         end else if ((state == NEXT) && (state_nxt == DONE)) begin
            BIST_done <= 1'b1;
            BIST_pass <= (Err_count == '0);
         end
      end
   end

endmodule
